// File: rtl/keypad_emulator_if.sv
// Request/status bundle between a key-press requester and the keypad emulator.
interface keypad_emulator_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       busy;

    modport master (
        output key_code,
        output key_valid,
        input  key_ready,
        input  busy
    );

    modport slave (
        input  key_code,
        input  key_valid,
        output key_ready,
        output busy
    );
endinterface

// File: rtl/keypad_emulator.sv
// Physical 4x4 matrix keypad model: answers the scanner's one-hot column drive
// with row lines for a commanded key, including LFSR-driven contact bounce.
module keypad_emulator #(
    parameter int unsigned BOUNCE_CYCLES = 4096,
    parameter int unsigned HOLD_CYCLES   = 2_000_000,
    parameter int unsigned GAP_CYCLES    = 1_000_000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         columnas,
    output logic [3:0]         filas,
    keypad_emulator_if.slave   req
);

    localparam int unsigned MAX_BH  = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_BH > GAP_CYCLES) ? MAX_BH : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

    // Each phase lasts exactly N cycles: load N-1, leave when the counter reads zero.
    localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'((BOUNCE_CYCLES == 0) ? 0 : BOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_BOUNCE_IN  = 3'd1;
    localparam logic [2:0] S_HOLD       = 3'd2;
    localparam logic [2:0] S_BOUNCE_OUT = 3'd3;
    localparam logic [2:0] S_GAP        = 3'd4;

    logic [2:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             contact_q, contact_d;
    logic [3:0]       col_sel_q, col_sel_d;
    logic [3:0]       row_sel_q, row_sel_d;
    logic [15:0]      lfsr_q,    lfsr_d;

    logic [3:0]       key_col_c;
    logic [3:0]       key_row_c;
    logic [15:0]      lfsr_step_c;

    // Code -> (column, row) position on the physical pad.
    always_comb begin
        key_col_c = 4'b0000;
        key_row_c = 4'b0000;
        case (req.key_code)
            4'h1: begin key_col_c = 4'b1000; key_row_c = 4'b1000; end
            4'h2: begin key_col_c = 4'b0100; key_row_c = 4'b1000; end
            4'h3: begin key_col_c = 4'b0010; key_row_c = 4'b1000; end
            4'hA: begin key_col_c = 4'b0001; key_row_c = 4'b1000; end
            4'h4: begin key_col_c = 4'b1000; key_row_c = 4'b0100; end
            4'h5: begin key_col_c = 4'b0100; key_row_c = 4'b0100; end
            4'h6: begin key_col_c = 4'b0010; key_row_c = 4'b0100; end
            4'hB: begin key_col_c = 4'b0001; key_row_c = 4'b0100; end
            4'h7: begin key_col_c = 4'b1000; key_row_c = 4'b0010; end
            4'h8: begin key_col_c = 4'b0100; key_row_c = 4'b0010; end
            4'h9: begin key_col_c = 4'b0010; key_row_c = 4'b0010; end
            4'hC: begin key_col_c = 4'b0001; key_row_c = 4'b0010; end
            4'hD: begin key_col_c = 4'b1000; key_row_c = 4'b0001; end
            4'h0: begin key_col_c = 4'b0100; key_row_c = 4'b0001; end
            4'hE: begin key_col_c = 4'b0010; key_row_c = 4'b0001; end
            default: begin key_col_c = 4'b0001; key_row_c = 4'b0001; end
        endcase
    end

    // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11, shifting toward bit 0.
    assign lfsr_step_c = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            contact_q <= 1'b0;
            col_sel_q <= 4'b0000;
            row_sel_q <= 4'b0000;
            lfsr_q    <= LFSR_SEED;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            contact_q <= contact_d;
            col_sel_q <= col_sel_d;
            row_sel_q <= row_sel_d;
            lfsr_q    <= lfsr_d;
        end
    end

    // contact_d is the level shown during the cycle that follows the edge;
    // the LFSR advances only on edges that load a bounce sample.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        contact_d = contact_q;
        col_sel_d = col_sel_q;
        row_sel_d = row_sel_q;
        lfsr_d    = lfsr_q;

        case (state_q)
            S_IDLE: begin
                contact_d = 1'b0;
                if (req.key_valid) begin
                    col_sel_d = key_col_c;
                    row_sel_d = key_row_c;
                    if (BOUNCE_CYCLES == 0) begin
                        state_d   = S_HOLD;
                        cnt_d     = HOLD_LOAD;
                        contact_d = 1'b1;
                    end else begin
                        state_d   = S_BOUNCE_IN;
                        cnt_d     = BOUNCE_LOAD;
                        contact_d = lfsr_q[0];
                        lfsr_d    = lfsr_step_c;
                    end
                end
            end

            S_BOUNCE_IN: begin
                if (cnt_q == '0) begin
                    state_d   = S_HOLD;
                    cnt_d     = HOLD_LOAD;
                    contact_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q - CNT_W'(1);
                    contact_d = lfsr_q[0];
                    lfsr_d    = lfsr_step_c;
                end
            end

            S_HOLD: begin
                if (cnt_q == '0) begin
                    if (BOUNCE_CYCLES == 0) begin
                        state_d   = S_GAP;
                        cnt_d     = GAP_LOAD;
                        contact_d = 1'b0;
                    end else begin
                        state_d   = S_BOUNCE_OUT;
                        cnt_d     = BOUNCE_LOAD;
                        contact_d = lfsr_q[0];
                        lfsr_d    = lfsr_step_c;
                    end
                end else begin
                    cnt_d     = cnt_q - CNT_W'(1);
                    contact_d = 1'b1;
                end
            end

            S_BOUNCE_OUT: begin
                if (cnt_q == '0) begin
                    state_d   = S_GAP;
                    cnt_d     = GAP_LOAD;
                    contact_d = 1'b0;
                end else begin
                    cnt_d     = cnt_q - CNT_W'(1);
                    contact_d = lfsr_q[0];
                    lfsr_d    = lfsr_step_c;
                end
            end

            S_GAP: begin
                contact_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                contact_d = 1'b0;
            end
        endcase
    end

    assign req.key_ready = (state_q == S_IDLE);
    assign req.busy      = (state_q != S_IDLE);

    // Zero-latency row response; a zero or multi-hot column drive never matches col_sel_q.
    assign filas = (contact_q && (columnas == col_sel_q)) ? row_sel_q : 4'b0000;

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboard bench for keypad_emulator: a bounce-free and a bouncing instance
// are checked every cycle against a per-cycle contact timeline built at acceptance.
module tb_keypad_emulator;

    localparam int unsigned HOLD = 64;
    localparam int unsigned GAP  = 8;
    localparam int unsigned B0   = 0;
    localparam int unsigned B1   = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct packed {
        logic       contact;
        logic [3:0] col;
        logic [3:0] row;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] columnas;
    logic [3:0] filas0, filas1;
    logic       mon_en;
    int         col_mode;
    int         col_step;

    int n_checks = 0;
    int n_pass   = 0;

    keypad_emulator_if if0();
    keypad_emulator_if if1();

    always #5 clk = ~clk;

    keypad_emulator #(.BOUNCE_CYCLES(B0), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .LFSR_SEED(SEED)) dut0 (
        .clk(clk), .reset(reset), .columnas(columnas), .filas(filas0), .req(if0)
    );
    keypad_emulator #(.BOUNCE_CYCLES(B1), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .LFSR_SEED(SEED)) dut1 (
        .clk(clk), .reset(reset), .columnas(columnas), .filas(filas1), .req(if1)
    );

    // ---------------- reference model ----------------
    logic [3:0]  layout [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'hD, 4'h0, 4'hE, 4'hF};
    exp_t        q0[$];
    exp_t        q1[$];
    int          m_left [2];
    logic [15:0] m_lfsr [2];
    int          acc_cnt [2];

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        int v;
        int fb;
        v  = int'(l);
        fb = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
        return 16'((v >> 1) | (fb << 15));
    endfunction

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic accept(input int d, input logic [3:0] code);
        int   pos;
        int   b;
        exp_t e;
        pos = 0;
        for (int i = 0; i < 16; i++) if (layout[i] == code) pos = i;
        b     = (d == 0) ? int'(B0) : int'(B1);
        e.col = 4'(8 >> (pos % 4));
        e.row = 4'(8 >> (pos / 4));
        for (int i = 0; i < b; i++) begin
            e.contact = m_lfsr[d][0];
            m_lfsr[d] = lfsr_next(m_lfsr[d]);
            push(d, e);
        end
        e.contact = 1'b1;
        for (int i = 0; i < int'(HOLD); i++) push(d, e);
        for (int i = 0; i < b; i++) begin
            e.contact = m_lfsr[d][0];
            m_lfsr[d] = lfsr_next(m_lfsr[d]);
            push(d, e);
        end
        e.contact = 1'b0;
        for (int i = 0; i < int'(GAP); i++) push(d, e);
        m_left[d]  = 2 * b + int'(HOLD) + int'(GAP);
        acc_cnt[d] = acc_cnt[d] + 1;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            q0.delete();
            q1.delete();
            m_left = '{0, 0};
            m_lfsr = '{SEED, SEED};
        end else begin
            if (m_left[0] == 0) begin
                if (if0.key_valid) accept(0, if0.key_code);
            end else m_left[0] = m_left[0] - 1;
            if (m_left[1] == 0) begin
                if (if1.key_valid) accept(1, if1.key_code);
            end else m_left[1] = m_left[1] - 1;
        end
    end

    // ---------------- monitor ----------------
    task automatic check(input string name, input int d, input logic [3:0] act, input logic [3:0] req_v);
        n_checks++;
        if (act === req_v) n_pass++;
        else $display("FAIL %s dut%0d t=%0t columnas=%b actual=%b required=%b",
                      name, d, $time, columnas, act, req_v);
    endtask

    task automatic check_dut(input int d, input logic [3:0] f, input logic rdy, input logic bsy);
        exp_t       e;
        logic       have;
        logic [3:0] exp_f;
        e    = '0;
        have = 1'b0;
        if (d == 0 && q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
        if (d == 1 && q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
        exp_f = (have && e.contact && columnas == e.col) ? e.row : 4'b0000;
        check("filas", d, f, exp_f);
        check("key_ready", d, {3'b000, rdy}, {3'b000, !have});
        check("busy", d, {3'b000, bsy}, {3'b000, have});
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check_dut(0, filas0, if0.key_ready, if0.busy);
            check_dut(1, filas1, if1.key_ready, if1.busy);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        int r;
        @(posedge clk);
        #1;
        case (col_mode)
            0: begin columnas = 4'(8 >> (col_step % 4)); col_step++; end
            1: columnas = 4'b1000;
            default: begin
                r = int'($urandom_range(0, 7));
                if (r < 4) columnas = 4'(8 >> r);
                else       columnas = 4'($urandom_range(0, 15));
            end
        endcase
    endtask

    task automatic press(input logic [3:0] c0, input logic [3:0] c1);
        int a0, a1, n;
        a0 = acc_cnt[0];
        a1 = acc_cnt[1];
        if0.key_code = c0; if0.key_valid = 1'b1;
        if1.key_code = c1; if1.key_valid = 1'b1;
        n = 0;
        while ((if0.key_valid || if1.key_valid) && n < 400) begin
            tick();
            if (acc_cnt[0] != a0) if0.key_valid = 1'b0;
            if (acc_cnt[1] != a1) if1.key_valid = 1'b0;
            n++;
        end
        if (if0.key_valid || if1.key_valid) begin
            n_checks++;
            $display("FAIL press_timeout t=%0t actual=pending required=accepted", $time);
            if0.key_valid = 1'b0;
            if1.key_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_left[0] != 0 || m_left[1] != 0) && n < 400) begin
            tick();
            n++;
        end
        if (m_left[0] != 0 || m_left[1] != 0) begin
            n_checks++;
            $display("FAIL idle_timeout t=%0t actual=busy required=idle", $time);
        end
        tick();
        tick();
    endtask

    initial begin
        mon_en   = 1'b0;
        col_mode = 0;
        col_step = 0;
        columnas = 4'b0000;
        acc_cnt  = '{0, 0};
        m_left   = '{0, 0};
        m_lfsr   = '{SEED, SEED};
        reset    = 1'b1;
        if0.key_code = 4'h5; if0.key_valid = 1'b1;
        if1.key_code = 4'h5; if1.key_valid = 1'b1;

        // Two reset cycles with a request pending: it must be dropped.
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        tick();
        reset = 1'b0;
        if0.key_valid = 1'b0;
        if1.key_valid = 1'b0;
        tick();
        tick();

        // Every code in turn under a rotating column scan.
        col_mode = 0;
        for (int c = 0; c < 16; c++) press(4'(c), 4'(c));
        wait_idle();

        // Key 1 with its column held: full bounce pattern visible on row 0.
        col_mode = 1;
        press(4'h1, 4'h1);
        wait_idle();

        // Second request arriving while busy is ignored.
        col_mode = 0;
        press(4'h9, 4'h9);
        for (int i = 0; i < 4; i++) tick();
        if0.key_code = 4'h2; if0.key_valid = 1'b1;
        if1.key_code = 4'h2; if1.key_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        if0.key_valid = 1'b0;
        if1.key_valid = 1'b0;
        wait_idle();

        // Reset during HOLD of E, then a full press of 0.
        press(4'hE, 4'hE);
        for (int i = 0; i < 30; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        press(4'h0, 4'h0);
        wait_idle();

        // Random requests, codes, column drive and occasional resets.
        col_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            reset         = ($urandom_range(0, 299) == 0);
            if0.key_valid = ($urandom_range(0, 3) == 0);
            if1.key_valid = ($urandom_range(0, 3) == 0);
            if0.key_code  = 4'($urandom_range(0, 15));
            if1.key_code  = 4'($urandom_range(0, 15));
            tick();
        end
        reset = 1'b0;
        if0.key_valid = 1'b0;
        if1.key_valid = 1'b0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
